multdiv_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 15 +
 rtl/twos_negate.sv | 14 +
 rtl/multdiv_unit.sv | 156 +++++++++++++++
 tb/tb_multdiv_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned MD_WIDTH   = 32;
    localparam int unsigned MD_CNT_W   = 5;
    localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } md_state_t;

endpackage

// File: rtl/twos_negate.sv
// Combinational conditional two's-complement negate.
module twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = en ? (~in + 1'b1) : in;
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: sign-magnitude operands, one shift-add or
// shift-subtract step per cycle, sign fixed up on the final iteration.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CntW = $clog2(WIDTH);

    md_state_t          r_state, w_state_d;
    logic [CntW-1:0]    r_cnt, w_cnt_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic [WIDTH-1:0]   r_opd, w_opd_d;
    logic               r_sign, w_sign_d;
    logic [WIDTH-1:0]   r_result, w_result_d;
    logic               r_exc, w_exc_d;
    logic               r_rdy, w_rdy_d;

    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_res_fix;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_prod_lo_z, w_mul_ovf, w_div_ovf;
    logic               w_start, w_last;

    twos_negate #(.WIDTH(WIDTH)) u_abs_a (
        .en  (data_operandA[WIDTH-1]),
        .in  (data_operandA),
        .out (w_abs_a)
    );

    twos_negate #(.WIDTH(WIDTH)) u_abs_b (
        .en  (data_operandB[WIDTH-1]),
        .in  (data_operandB),
        .out (w_abs_b)
    );

    twos_negate #(.WIDTH(WIDTH)) u_res_fix (
        .en  (r_sign),
        .in  (w_step[WIDTH-1:0]),
        .out (w_res_fix)
    );

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == {CntW{1'b1}});

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; remainder < divisor keeps the top bit clear.
    assign w_rem_sh   = r_acc[2*WIDTH-2:WIDTH-1];
    assign w_div_diff = {1'b0, w_rem_sh} - {1'b0, r_opd};
    assign w_div_next = w_div_diff[WIDTH] ? {w_rem_sh, r_acc[WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_step = (r_state == StDiv) ? w_div_next : w_mul_next;

    // Magnitude must fit: below 2^31 when positive, at most 2^31 when negative.
    assign w_prod_hi   = w_step[2*WIDTH-1:WIDTH-1];
    assign w_prod_lo_z = (w_step[WIDTH-2:0] == '0);
    assign w_mul_ovf   = r_sign ? ((|w_prod_hi[WIDTH:1]) | (w_prod_hi[0] & ~w_prod_lo_z))
                                : (|w_prod_hi);
    assign w_div_ovf   = ~r_sign & w_step[WIDTH-1];

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_acc_d    = r_acc;
        w_opd_d    = r_opd;
        w_sign_d   = r_sign;
        w_result_d = r_result;
        w_exc_d    = r_exc;
        w_rdy_d    = 1'b0;

        unique case (r_state)
            StMul, StDiv: begin
                w_acc_d = w_step;
                w_cnt_d = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_d  = StDone;
                    w_rdy_d    = 1'b1;
                    w_result_d = w_res_fix;
                    w_exc_d    = (r_state == StMul) ? w_mul_ovf : w_div_ovf;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // A new start silently discards any operation in flight, including its completion.
        if (w_start) begin
            w_cnt_d    = '0;
            w_sign_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            w_rdy_d    = 1'b0;
            w_result_d = r_result;
            w_exc_d    = r_exc;
            if (ctrl_MULT) begin
                w_state_d = StMul;
                w_acc_d   = {{WIDTH{1'b0}}, w_abs_b};
                w_opd_d   = w_abs_a;
            end else if (data_operandB == '0) begin
                w_state_d  = StDone;
                w_rdy_d    = 1'b1;
                w_result_d = '0;
                w_exc_d    = 1'b1;
            end else begin
                w_state_d = StDiv;
                w_acc_d   = {{WIDTH{1'b0}}, w_abs_a};
                w_opd_d   = w_abs_b;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_acc    <= w_acc_d;
            r_opd    <= w_opd_d;
            r_sign   <= w_sign_d;
            r_result <= w_result_d;
            r_exc    <= w_exc_d;
            r_rdy    <= w_rdy_d;
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed scoreboard bench for multdiv_unit: latency, results, exceptions, abort and reset.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference using 64-bit signed arithmetic.
    function automatic exp_t model(input logic m, input logic d, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa, sbv, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.lat = 33;
        if (m) begin
            r     = sa * sbv;
            e.res = r[31:0];
            e.exc = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end else if (d && b == 32'h0) begin
            e.res = '0;
            e.exc = 1'b1;
            e.lat = 1;
        end else begin
            r     = sa / sbv;
            e.res = r[31:0];
            e.exc = (r > 64'sd2147483647);
        end
        return e;
    endfunction

    // Drives a one-cycle start (in the current cycle if now=1), then scrambles operands.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input bit now);
        if (!now) @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic do_op(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input bit now);
        sb.push_back(model(m, d, a, b));
        start_op(m, d, a, b, now);
    endtask

    // Called mid-cycle T+1; n counts the cycle index relative to the start edge.
    task automatic wait_check(input string tag, input bit drop);
        exp_t e;
        int   n = 1;
        while (data_resultRDY !== 1'b1 && n < 80) begin
            @(negedge clock);
            n++;
        end
        e = sb.pop_front();
        check({tag, ".lat"}, 64'(n), 64'(e.lat));
        check({tag, ".res"}, 64'(data_result), 64'(e.res));
        check({tag, ".exc"}, 64'(data_exception), 64'(e.exc));
        if (drop) begin
            @(negedge clock);
            check({tag, ".rdy_drop"}, 64'(data_resultRDY), 64'(0));
        end
    endtask

    logic [31:0] ta[8];
    logic [31:0] tbv[8];
    logic        tm[8];

    initial begin
        int rdy_seen;
        ta  = '{32'd7, 32'h0001_0000, -32'sd100, 32'd5, MD_INT_MIN, MD_INT_MIN, MD_INT_MIN, -32'sd7};
        tbv = '{-32'sd6, 32'h0001_0000, 32'd7, 32'd0, -32'sd1, 32'd1, -32'sd1, 32'd2};
        tm  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset.res", 64'(data_result), 64'(0));
        check("reset.exc", 64'(data_exception), 64'(0));
        check("reset.rdy", 64'(data_resultRDY), 64'(0));

        for (int i = 0; i < 8; i++) begin
            do_op(tm[i], !tm[i], ta[i], tbv[i], 1'b0);
            wait_check($sformatf("op%0d", i), 1'b1);
        end

        do_op(1'b1, 1'b0, 32'h7fff_ffff, 32'h7fff_ffff, 1'b0);
        wait_check("mul_max", 1'b1);

        // Abort: MULT at T, DIV at T+10 -> only the divide completes, at T+43.
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("abort.early_rdy", 64'(rdy_seen), 64'(0));
        do_op(1'b0, 1'b1, 32'd20, 32'd4, 1'b0);
        wait_check("abort.div", 1'b1);

        // Both controls high: multiply wins; next start is issued during the DONE cycle.
        do_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b0);
        wait_check("both", 1'b0);
        do_op(1'b0, 1'b1, -32'sd45, -32'sd6, 1'b1);
        wait_check("start_in_done", 1'b1);

        // Leave non-zero outputs, then reset during an operation.
        do_op(1'b0, 1'b1, MD_INT_MIN, -32'sd1, 1'b0);
        wait_check("pre_reset", 1'b1);
        start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset.res", 64'(data_result), 64'(0));
        check("midreset.exc", 64'(data_exception), 64'(0));
        check("midreset.rdy", 64'(data_resultRDY), 64'(0));
        rdy_seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("midreset.no_rdy", 64'(rdy_seen), 64'(0));
        check("sb.empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
